// File: rtl/interp_stream_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// interp_pkg
// Shared types and constants for the interpolation stream controller:
//   sample_t       8-bit unsigned input sample
//   result_t       40-bit two's-complement datapath word
//   interp_state_t controller states FILL / RUN / EMIT
// Helpers:
//   ext()      zero-extends a sample to a datapath word
//   sat_word() arithmetic shift right by SAT_SHIFT, clamped to [0,255]
//              (used only when INTERP_STREAM_SAT_EN is defined)
// -----------------------------------------------------------------------------
package interp_pkg;

  typedef logic [7:0]  sample_t;
  typedef logic [39:0] result_t;

  typedef enum logic [1:0] {
    FILL = 2'd0,
    RUN  = 2'd1,
    EMIT = 2'd2
  } interp_state_t;

  localparam int BUF_DEPTH  = 8;
  localparam int CENTRE_IDX = 4;
  localparam int SAT_SHIFT  = 6;

  function automatic result_t ext(input sample_t s);
    return {32'd0, s};
  endfunction

  function automatic result_t sat_word(input result_t v);
    logic signed [39:0] sh;
    sh = $signed(v) >>> SAT_SHIFT;
    if (sh < 40'sd0) begin
      return '0;
    end else if (sh > 40'sd255) begin
      return 40'd255;
    end else begin
      return result_t'(sh);
    end
  endfunction

endpackage

// File: rtl/interp_stream_ctrl_if.sv
// -----------------------------------------------------------------------------
// interp_stream_ctrl_if
// Input and output stream handshake of the interpolation controller.
// Handshake rule (both streams): a transfer happens on a rising clock edge
// where valid && ready; the producer holds data stable while valid && !ready.
//   in_data/in_valid   sample stream into the block, in_ready back-pressure
//   out_data/out_phase result stream out of the block, out_valid/out_ready
// Modports:
//   slave  - the controller (accepts samples, produces results)
//   master - the environment (sample source and result consumer)
// -----------------------------------------------------------------------------
interface interp_stream_ctrl_if;
  import interp_pkg::*;

  sample_t     in_data;
  logic        in_valid;
  logic        in_ready;
  result_t     out_data;
  logic [1:0]  out_phase;
  logic        out_valid;
  logic        out_ready;

  modport slave (
    input  in_data, in_valid, out_ready,
    output in_ready, out_data, out_phase, out_valid
  );

  modport master (
    output in_data, in_valid, out_ready,
    input  in_ready, out_data, out_phase, out_valid
  );

endinterface

// File: rtl/interp_stream_ctrl_kernel.sv
// -----------------------------------------------------------------------------
// interp_kernel
// Combinational 8-tap interpolation datapath. Instantiates the three tap
// modules on the shift buffer and returns the A, B and C interpolants as
// 40-bit two's-complement words.
// Ports:
//   taps_i  buffer contents, taps_i[0] newest .. taps_i[7] oldest
//   aValue  A interpolant
//   bValue  B interpolant
//   cValue  C interpolant
// Tap coefficients (index 0..7):
//   A:  1  -4  10  58  17  -5   1  -6
//   B: -1   4 -11  40  40 -11   4 -11
//   C: -1   1  -5  17  58 -10   4   8
// All arithmetic is modulo 2^40, so subtracting zero-extended products yields
// the correct two's-complement result.
// -----------------------------------------------------------------------------
module getAValSimple
  import interp_pkg::*;
(
  input  sample_t [BUF_DEPTH-1:0] taps_i,
  output result_t                 value_o
);
  assign value_o = ext(taps_i[0])
                 - 40'd4  * ext(taps_i[1])
                 + 40'd10 * ext(taps_i[2])
                 + 40'd58 * ext(taps_i[3])
                 + 40'd17 * ext(taps_i[4])
                 - 40'd5  * ext(taps_i[5])
                 + ext(taps_i[6])
                 - 40'd6  * ext(taps_i[7]);
endmodule

module getBValSimple
  import interp_pkg::*;
(
  input  sample_t [BUF_DEPTH-1:0] taps_i,
  output result_t                 value_o
);
  assign value_o = 40'd4  * ext(taps_i[1])
                 - ext(taps_i[0])
                 - 40'd11 * ext(taps_i[2])
                 + 40'd40 * ext(taps_i[3])
                 + 40'd40 * ext(taps_i[4])
                 - 40'd11 * ext(taps_i[5])
                 + 40'd4  * ext(taps_i[6])
                 - 40'd11 * ext(taps_i[7]);
endmodule

module getCValSimple
  import interp_pkg::*;
(
  input  sample_t [BUF_DEPTH-1:0] taps_i,
  output result_t                 value_o
);
  assign value_o = ext(taps_i[1])
                 - ext(taps_i[0])
                 - 40'd5  * ext(taps_i[2])
                 + 40'd17 * ext(taps_i[3])
                 + 40'd58 * ext(taps_i[4])
                 - 40'd10 * ext(taps_i[5])
                 + 40'd4  * ext(taps_i[6])
                 + 40'd8  * ext(taps_i[7]);
endmodule

module interp_kernel
  import interp_pkg::*;
(
  input  sample_t [BUF_DEPTH-1:0] taps_i,
  output result_t                 aValue,
  output result_t                 bValue,
  output result_t                 cValue
);
  getAValSimple u_a (.taps_i(taps_i), .value_o(aValue));
  getBValSimple u_b (.taps_i(taps_i), .value_o(bValue));
  getCValSimple u_c (.taps_i(taps_i), .value_o(cValue));
endmodule

// File: rtl/interp_stream_ctrl.sv
// -----------------------------------------------------------------------------
// interp_stream_ctrl
// 4x upsampling stream sequencer. Samples enter an 8-entry shift buffer; once
// the buffer has been filled, every accepted sample is followed by four
// output words: centre sample (phase 0), then A, B, C interpolants.
// Ports:
//   clock        system clock, rising edge
//   reset        synchronous active-high reset
//   flush        synchronous clear of buffer, fill count and pending phases
//   s            stream interface (slave modport): in_* and out_* handshakes
//   fill_level   buffer occupancy 0..8 (stays 8 once filled)
//   dbg_state_o  current controller state
// Configuration:
//   INTERP_STREAM_SAT_EN  when defined, phases 1..3 are shifted right by 6
//                         and clamped to [0,255]; otherwise raw 40-bit words.
// -----------------------------------------------------------------------------
module interp_stream_ctrl
  import interp_pkg::*;
(
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  flush,
  interp_stream_ctrl_if.slave   s,
  output logic [3:0]            fill_level,
  output interp_state_t         dbg_state_o
);

  interp_state_t            state_q, state_d;
  logic [1:0]               phase_q, phase_d;
  logic [3:0]               fill_q,  fill_d;
  sample_t [BUF_DEPTH-1:0]  buf_q,   buf_d;

  result_t a_val, b_val, c_val;
  result_t a_word, b_word, c_word;
  result_t word;

  logic out_valid;
  logic out_hs;
  logic early_acc;
  logic in_ready;
  logic accept;

  interp_kernel u_kernel (
    .taps_i (buf_q),
    .aValue (a_val),
    .bValue (b_val),
    .cValue (c_val)
  );

`ifdef INTERP_STREAM_SAT_EN
  assign a_word = sat_word(a_val);
  assign b_word = sat_word(b_val);
  assign c_word = sat_word(c_val);
`else
  assign a_word = a_val;
  assign b_word = b_val;
  assign c_word = c_val;
`endif

  // Handshake decode. The only combinational input-to-output path is the
  // early accept in EMIT phase 3, which lets a new sample overlap the last
  // output word and sustain one input every four cycles.
  always_comb begin
    out_valid = (state_q == EMIT);
    out_hs    = out_valid && s.out_ready;
    early_acc = out_hs && (phase_q == 2'd3) && s.in_valid;
    in_ready  = !reset && !flush && ((state_q != EMIT) || early_acc);
    accept    = s.in_valid && in_ready;
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    phase_d = phase_q;
    fill_d  = fill_q;
    buf_d   = buf_q;

    if (flush) begin
      state_d = FILL;
      phase_d = 2'd0;
      fill_d  = 4'd0;
      buf_d   = '0;
    end else begin
      if (accept) begin
        buf_d = {buf_q[BUF_DEPTH-2:0], s.in_data};
      end
      unique case (state_q)
        FILL: begin
          if (accept) begin
            fill_d = fill_q + 4'd1;
            if (fill_q == 4'(BUF_DEPTH - 1)) begin
              state_d = EMIT;
              phase_d = 2'd0;
            end
          end
        end
        RUN: begin
          if (accept) begin
            state_d = EMIT;
            phase_d = 2'd0;
          end
        end
        EMIT: begin
          if (out_hs) begin
            if (phase_q == 2'd3) begin
              phase_d = 2'd0;
              state_d = accept ? EMIT : RUN;
            end else begin
              phase_d = phase_q + 2'd1;
            end
          end
        end
        default: begin
          state_d = FILL;
        end
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= FILL;
      phase_q <= 2'd0;
      fill_q  <= 4'd0;
      buf_q   <= '0;
    end else begin
      state_q <= state_d;
      phase_q <= phase_d;
      fill_q  <= fill_d;
      buf_q   <= buf_d;
    end
  end

  // Output word select; forced to zero when no word is offered.
  always_comb begin
    word = '0;
    unique case (phase_q)
      2'd0:    word = ext(buf_q[CENTRE_IDX]);
      2'd1:    word = a_word;
      2'd2:    word = b_word;
      default: word = c_word;
    endcase
  end

  assign s.in_ready  = in_ready;
  assign s.out_valid = out_valid;
  assign s.out_data  = out_valid ? word : '0;
  assign s.out_phase = out_valid ? phase_q : 2'd0;
  assign fill_level  = fill_q;
  assign dbg_state_o = state_q;

endmodule
